// File: rtl/serial_arith_unit.sv
// Digit-serial add/subtract unit: DIGIT chained full adders per clock with the
// carry held in a register between digits; valid/ready on both sides.
module serial_arith_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] resultReg;
    logic             carryReg;
    logic [CW-1:0]    counter;
    logic             carryOutReg;
    logic             overflowReg;
    logic             zeroReg;
    logic             outValidReg;

    logic [DIGIT:0]   chainCarry;
    logic [DIGIT-1:0] sumDigit;
    logic [WIDTH-1:0] resultNext;

    assign chainCarry[0] = carryReg;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign sumDigit[gi]     = aReg[gi] ^ bReg[gi] ^ chainCarry[gi];
            assign chainCarry[gi+1] = (aReg[gi] & bReg[gi]) |
                                      (chainCarry[gi] & (aReg[gi] ^ bReg[gi]));
        end
        // New sum digits enter at the top; after N cycles the first digit sits at bit 0.
        if (DIGIT == WIDTH) begin : g_single
            assign resultNext = sumDigit;
        end else begin : g_shift
            assign resultNext = {sumDigit, resultReg[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            aReg        <= '0;
            bReg        <= '0;
            resultReg   <= '0;
            carryReg    <= 1'b0;
            counter     <= '0;
            carryOutReg <= 1'b0;
            overflowReg <= 1'b0;
            zeroReg     <= 1'b0;
            outValidReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        aReg     <= a;
                        // Subtraction is a + ~b + 1; SBC supplies its own carry.
                        bReg     <= op[0] ? ~b : b;
                        carryReg <= op[1] ? cin : op[0];
                        counter  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    aReg      <= aReg >> DIGIT;
                    bReg      <= bReg >> DIGIT;
                    resultReg <= resultNext;
                    carryReg  <= chainCarry[DIGIT];
                    counter   <= counter + CW'(1);
                    if (counter == CW'(N - 1)) begin
                        carryOutReg <= chainCarry[DIGIT];
                        overflowReg <= chainCarry[DIGIT-1] ^ chainCarry[DIGIT];
                        zeroReg     <= (resultNext == '0);
                        outValidReg <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValidReg <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = outValidReg;
    assign result    = resultReg;
    assign carry_out = carryOutReg;
    assign overflow  = overflowReg;
    assign zero      = zeroReg;
endmodule

// File: tb/tb_serial_arith_unit.sv
// Scoreboard bench for serial_arith_unit: a bit-serial (DIGIT=1) and a nibble
// (DIGIT=4) instance, checked against an integer-arithmetic reference model.
module tb_serial_arith_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       inValid [2];
    logic       inReady [2];
    logic [7:0] a, b;
    logic [1:0] op;
    logic       cin;
    logic       outValid [2];
    logic       outReady;
    logic [7:0] result [2];
    logic       carryOut [2];
    logic       overflow [2];
    logic       zero [2];
    logic       busy [2];

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
    } expT;

    expT expQ0[$];
    expT expQ1[$];
    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;
    int  acceptCyc [2];
    bit  prevValid [2];
    bit  randReady = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_arith_unit #(.WIDTH(8), .DIGIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(outValid[0]), .out_ready(outReady),
        .result(result[0]), .carry_out(carryOut[0]), .overflow(overflow[0]),
        .zero(zero[0]), .busy(busy[0])
    );

    serial_arith_unit #(.WIDTH(8), .DIGIT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(outValid[1]), .out_ready(outReady),
        .result(result[1]), .carry_out(carryOut[1]), .overflow(overflow[1]),
        .zero(zero[1]), .busy(busy[1])
    );

    function automatic int latencyOf(int i);
        return (i == 0) ? 8 : 2;
    endfunction

    // Reference: plain integer sums, signed overflow from the true signed range.
    function automatic expT model(logic [1:0] o, logic [7:0] x, logic [7:0] y, logic ci);
        expT e;
        logic [7:0] yy;
        logic signed [7:0] sx, sy;
        int c0, u, s;
        yy = o[0] ? ~y : y;
        c0 = (o == 2'b00) ? 0 : (o == 2'b01) ? 1 : int'(ci);
        u  = int'(x) + int'(yy) + c0;
        sx = x;
        sy = yy;
        s  = int'(sx) + int'(sy) + c0;
        e.res = u[7:0];
        e.c   = u[8];
        e.v   = (s > 127) || (s < -128);
        e.z   = (u[7:0] == 8'h00);
        return e;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Caller is always positioned 1 time unit after a rising edge.
    task automatic issue(input int i, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic ci, input bit push);
        int t = 0;
        while (!inReady[i] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!inReady[i]) begin
            check($sformatf("in_ready_wait_dut%0d", i), int'(inReady[i]), 1);
            return;
        end
        a = x; b = y; op = o; cin = ci;
        inValid[i] = 1'b1;
        if (push) begin
            if (i == 0) expQ0.push_back(model(o, x, y, ci));
            else        expQ1.push_back(model(o, x, y, ci));
        end
        @(posedge clk); #1;
        inValid[i]   = 1'b0;
        acceptCyc[i] = cyc;
    endtask

    task automatic monitorStep(input int i);
        expT e, g;
        bit  empty;
        if (outValid[i] && !prevValid[i])
            check($sformatf("latency_dut%0d", i), cyc - acceptCyc[i], latencyOf(i));
        if (outValid[i] && outReady) begin
            empty = (i == 0) ? (expQ0.size() == 0) : (expQ1.size() == 0);
            if (empty) begin
                check($sformatf("unexpected_result_dut%0d", i), int'(outValid[i]), 0);
            end else begin
                e = (i == 0) ? expQ0.pop_front() : expQ1.pop_front();
                g = '{res: result[i], c: carryOut[i], v: overflow[i], z: zero[i]};
                compared++;
                if (g !== e) begin
                    mismatched++;
                    $display("FAIL txn dut%0d: got res=%02h c=%0d v=%0d z=%0d, expected res=%02h c=%0d v=%0d z=%0d",
                             i, g.res, g.c, g.v, g.z, e.res, e.c, e.v, e.z);
                end else begin
                    $display("txn dut%0d: res=%02h c=%0d v=%0d z=%0d ok", i, g.res, g.c, g.v, g.z);
                end
            end
        end
        prevValid[i] = outValid[i];
    endtask

    always @(negedge clk) begin
        monitorStep(0);
        monitorStep(1);
    end

    always @(posedge clk) begin
        #1;
        if (randReady) outReady = 1'($urandom_range(0, 1));
    end

    initial begin
        int t;
        rst_n = 1'b0;
        inValid[0] = 1'b0; inValid[1] = 1'b0;
        outReady = 1'b0;
        a = '0; b = '0; op = '0; cin = 1'b0;
        prevValid[0] = 1'b0; prevValid[1] = 1'b0;
        acceptCyc[0] = 0; acceptCyc[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_out_valid%0d", i), int'(outValid[i]), 0);
            check($sformatf("rst_result%0d", i), int'(result[i]), 0);
            check($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            check($sformatf("rst_in_ready%0d", i), int'(inReady[i]), 1);
            check($sformatf("rst_flags%0d", i), int'({carryOut[i], overflow[i], zero[i]}), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b1;

        // Directed cases on the bit-serial instance.
        issue(0, 2'b00, 8'h55, 8'h2A, 1'b0, 1'b1);
        issue(0, 2'b00, 8'hFF, 8'h01, 1'b0, 1'b1);
        issue(0, 2'b01, 8'h80, 8'h01, 1'b0, 1'b1);
        issue(0, 2'b01, 8'h00, 8'h01, 1'b1, 1'b1);
        // Nibble instance: ADC / SBC with carry-in.
        issue(1, 2'b10, 8'h7F, 8'h00, 1'b1, 1'b1);
        issue(1, 2'b11, 8'h10, 8'h0F, 1'b1, 1'b1);

        // Backpressure: outputs hold in DONE and new operands are ignored.
        issue(0, 2'b00, 8'h12, 8'h34, 1'b0, 1'b0);
        outReady = 1'b0;
        expQ0.push_back(model(2'b00, 8'h12, 8'h34, 1'b0));
        t = 0;
        while (!outValid[0] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_out_valid", int'(outValid[0]), 1);
        for (int k = 0; k < 5; k++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            inValid[0] = 1'b1;
            @(posedge clk); #1;
            check("bp_hold_result", int'(result[0]), 8'h46);
            check("bp_hold_flags", int'({carryOut[0], overflow[0], zero[0]}), 0);
            check("bp_in_ready", int'(inReady[0]), 0);
            check("bp_hold_valid", int'(outValid[0]), 1);
        end
        inValid[0] = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", int'(outValid[0]), 0);
        check("bp_release_idle", int'(inReady[0]), 1);

        // Reset three cycles into RUN aborts with no result.
        issue(0, 2'b00, 8'hAB, 8'hCD, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(outValid[0]), 0);
        check("abort_result", int'(result[0]), 0);
        check("abort_busy", int'(busy[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(0, 2'b00, 8'h01, 8'h01, 1'b0, 1'b1);

        // Randomized traffic with random consumer backpressure.
        randReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            repeat (40) issue(i, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        @(posedge clk); #1;
        randReady = 1'b0;
        outReady = 1'b1;
        t = 0;
        while ((expQ0.size() != 0 || expQ1.size() != 0) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", expQ0.size() + expQ1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/serial_arith_unit.md
Name: serial_arith_unit

Overview:
- Multi-cycle, parametrised arithmetic unit. Adds or subtracts two WIDTH-bit operands DIGIT bits per clock through a chain of DIGIT full-adder slices, holding the carry in a register between digits.
- Provides add/sub with optional carry-in, plus carry, signed-overflow and zero flags.
- Sits between an operand source and a result consumer. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle (1 = bit-serial, WIDTH = single-cycle ripple).
- N (localparam), WIDTH/DIGIT, number of compute cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  operands and op present
- in_ready  output  1  unit can accept an operation
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- op  input  2  00 ADD a+b, 01 SUB a-b, 10 ADC a+b+cin, 11 SBC a+~b+cin
- cin  input  1  carry-in, used only by ADC/SBC
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  sum/difference modulo 2^WIDTH
- carry_out  output  1  carry out of MSB; for SUB/SBC, 1 = no borrow (a >= b unsigned)
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)
- zero  output  1  result == 0
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, counter = 0, carry register = 0.
  - result = 0, carry_out = 0, overflow = 0, zero = 0, out_valid = 0, busy = 0.
  - Reset mid-RUN or in DONE aborts the operation. No result is produced.
- State machine, three states:
  - IDLE:
    - in_ready = 1.
    - On a clock edge with in_valid && in_ready, latch:
      - A shift register ← a.
      - B shift register ← b for ADD/ADC, ~b for SUB/SBC.
      - Carry register ← 0 (ADD), 1 (SUB), cin (ADC/SBC).
      - counter ← 0.
      - state → RUN.
  - RUN:
    - in_ready = 0.
    - Each cycle, the DIGIT LSBs of A and B plus the carry register pass through DIGIT chained full adders.
    - The DIGIT sum bits shift into the result shift register from the top. A and B shift right by DIGIT. The carry register takes the chain carry-out. counter increments.
    - On the cycle where counter == N-1:
      - Also capture the carry into the MSB slice. overflow = that carry XOR the final carry.
      - carry_out = final carry.
      - state → DONE.
  - DONE:
    - out_valid = 1. result, carry_out, overflow and zero are registered and stable.
    - zero is computed from the full result register.
    - Outputs hold while out_ready = 0, for any number of cycles.
    - On an edge with out_ready = 1: out_valid → 0 and state → IDLE.
    - Flag outputs keep their last values until the next DONE. result keeps shifting during the next RUN and is meaningful only while out_valid = 1.
- Timing:
  - If the accept edge is edge k, out_valid rises after edge k+N.
  - Minimum issue interval is N+2 cycles (accept, N compute, handshake). No overlap of operations.
- Boundary rules:
  - in_valid while not in IDLE is ignored. Operands are not sampled.
  - cin is ignored for ADD/SUB.
  - DIGIT = WIDTH gives N = 1: out_valid after one compute cycle.
  - For DIGIT = 1, the carry into the MSB is the carry register value entering the last cycle.
  - Simultaneous in_valid and rst_n deassertion: nothing is accepted until the first edge with rst_n high.
  - All arithmetic is modulo 2^WIDTH. Flags follow the definitions above for every op.

Test Plan:
1. WIDTH=8, DIGIT=1, ADD a=0x55, b=0x2A → result 0x7F, carry_out 0, overflow 0, zero 0. out_valid asserts exactly 8 cycles after the accept edge.
2. ADD a=0xFF, b=0x01 → result 0x00, carry_out 1, overflow 0, zero 1.
3. SUB a=0x80, b=0x01 → result 0x7F, carry_out 1, overflow 1. Then SUB a=0x00, b=0x01 → result 0xFF, carry_out 0, overflow 0.
4. WIDTH=8, DIGIT=4, ADC a=0x7F, b=0x00, cin=1 → result 0x80, overflow 1, carry_out 0, latency 2 cycles. Then SBC a=0x10, b=0x0F, cin=1 → result 0x01, carry_out 1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands → result and flags unchanged, in_ready 0, pulsed operands never processed. Raising out_ready returns to IDLE on the next edge.
6. Assert rst_n low 3 cycles into RUN → out_valid 0, result 0, busy 0 immediately. After release, a new ADD 0x01+0x01 completes with result 0x02.
